// File: rtl/adc_init_pkg.sv
// adc_init_pkg: shared state encodings and frame geometry for the ADC init sequencer
package adc_init_pkg;
  localparam int FRAME_BITS = 24;
  localparam int ADDR_W = 4;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RST_PULSE = 3'd1;
  localparam logic [2:0] S_PWR_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_CS_GAP    = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
endpackage

// File: rtl/adc_init_seq_spi.sv
// adc_spi_shifter: one 24-bit MSB-first frame per load strobe, SCLK idles low, data changes on SCLK low
module adc_spi_shifter
  import adc_init_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [FRAME_BITS-1:0] data_i,
  output logic                  cs_b_o,
  output logic                  sclk_o,
  output logic                  sdata_o,
  output logic                  done_o
);
  logic                  active_q, active_d;
  logic [15:0]           div_q, div_d;
  logic [4:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] sreg_q, sreg_d;
  logic                  cs_b_q, cs_b_d, sclk_q, sclk_d, sdata_q, sdata_d;
  logic                  tick;
  assign tick    = div_q == 16'(SCLK_DIV - 1);
  // high during the last cycle of a frame, so the caller can change state on the same edge
  assign done_o  = active_q && sclk_q && tick && bit_q == 5'(FRAME_BITS - 1);
  assign cs_b_o  = cs_b_q;
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    cs_b_d   = cs_b_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    if (clr_i) begin
      active_d = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      cs_b_d   = 1'b1;
      sclk_d   = 1'b0;
      sdata_d  = 1'b0;
    end else if (load_i) begin
      active_d = 1'b1;
      div_d    = '0;
      bit_d    = '0;
      sreg_d   = data_i;
      cs_b_d   = 1'b0;
      sclk_d   = 1'b0;
      sdata_d  = data_i[FRAME_BITS-1];
    end else if (active_q) begin
      div_d  = tick ? '0 : div_q + 16'd1;
      sclk_d = sclk_q ^ tick;
      if (tick && sclk_q) begin
        active_d = !done_o;
        cs_b_d   = done_o;
        bit_d    = bit_q + 5'd1;
        sreg_d   = sreg_q << 1;
        sdata_d  = sreg_q[FRAME_BITS-2];
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sreg_q   <= '0;
      cs_b_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sreg_q   <= sreg_d;
      cs_b_q   <= cs_b_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
    end
  end
endmodule

// File: rtl/adc_init_seq.sv
// adc_init_seq: ADC reset pulse, settle wait and NREG config frames, then ADC_RDY.
// Optional ADC_FRAME_CNT_EN adds a saturating frames_sent_o counter cleared only by rst_i.
module adc_init_seq
  import adc_init_pkg::*;
#(
  parameter int NREG     = 4,
  parameter int RST_PW   = 20,
  parameter int PWR_WAIT = 1000,
  parameter int SCLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  adc_init_rst_i,
  input  logic [FRAME_BITS-1:0] cfg_data_i,
  output logic [ADDR_W-1:0]     cfg_addr_o,
  output logic                  adc_rst_b_o,
  output logic                  adc_cs_b_o,
  output logic                  adc_sclk_o,
  output logic                  adc_sdata_o,
  output logic                  adc_rdy_o,
  output logic [2:0]            init_state_o
`ifdef ADC_FRAME_CNT_EN
  ,
  output logic [7:0]            frames_sent_o
`endif
);
  logic [2:0]        state_q, state_d;
  logic [15:0]       timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rst_b_q, rdy_q, spi_done, enter;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_RST_PULSE;
      S_RST_PULSE: state_d = timer_q == 16'(RST_PW - 1) ? S_PWR_WAIT : state_q;
      S_PWR_WAIT:  state_d = timer_q == 16'(PWR_WAIT - 1) ? S_SHIFT : state_q;
      S_SHIFT:     state_d = spi_done ? S_CS_GAP : state_q;
      S_CS_GAP:    state_d = timer_q != 16'(SCLK_DIV - 1) ? state_q :
                             addr_q == ADDR_W'(NREG) ? S_DONE : S_SHIFT;
      S_DONE:      state_d = S_DONE;
      default:     state_d = S_IDLE;
    endcase
    if (adc_init_rst_i) state_d = S_IDLE;
  end
  assign enter   = state_d != state_q;
  assign timer_d = enter ? '0 : timer_q + 16'd1;
  assign addr_d  = (state_d == S_IDLE || (state_d == S_PWR_WAIT && enter)) ? '0 :
                   (state_d == S_CS_GAP && enter) ? addr_q + 1'b1 : addr_q;
  adc_spi_shifter #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (state_d == S_IDLE),
    .load_i  (state_d == S_SHIFT && enter),
    .data_i  (cfg_data_i),
    .cs_b_o  (adc_cs_b_o),
    .sclk_o  (adc_sclk_o),
    .sdata_o (adc_sdata_o),
    .done_o  (spi_done)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      rst_b_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      rst_b_q <= !(state_d == S_IDLE || state_d == S_RST_PULSE);
      rdy_q   <= state_d == S_DONE;
    end
  end
  assign cfg_addr_o   = addr_q;
  assign adc_rst_b_o  = rst_b_q;
  assign adc_rdy_o    = rdy_q;
  assign init_state_o = state_q;
`ifdef ADC_FRAME_CNT_EN
  logic [7:0] frames_q;
  // a frame counts only if it reaches its final SCLK fall without an abort
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) frames_q <= '0;
    else if (spi_done && !adc_init_rst_i && frames_q != 8'hFF) frames_q <= frames_q + 8'd1;
  end
  assign frames_sent_o = frames_q;
`endif
endmodule

// File: tb/tb_adc_init_seq.sv
// tb_adc_init_seq: timeline/frame checks of adc_init_seq against spec-derived expectations
module tb_adc_init_seq;
  localparam int RST_PW = 20, PWR_WAIT = 1000, NREG = 4, DIV = 4;
  localparam int T0 = RST_PW + PWR_WAIT + NREG * 49 * DIV;
  logic clk = 1'b0, rst = 1'b1, init_rst = 1'b1, sel = 1'b0;
  logic [19:0] pat = 20'hA5A50;
  logic [3:0] addr0, addr1;
  logic rstb0, cs0, sclk0, sd0, rdy0, rstb1, cs1, sclk1, sd1, rdy1;
  logic [2:0] st0, st1;
  logic o_rstb, o_cs, o_sclk, o_sd, o_rdy;
  logic [2:0] o_st;
  logic [3:0] o_addr;
`ifdef ADC_FRAME_CNT_EN
  logic [7:0] fr0, fr1;
`endif
  int checks = 0, errors = 0;
  int rstb_rise, rdy_rise, first_cs, viol;
  int runs[$], gaps[$], bits[$];
  logic [23:0] words[$];
  always #5 clk = ~clk;
  adc_init_seq u0 (
    .clk_i(clk), .rst_i(rst), .adc_init_rst_i(init_rst), .cfg_data_i({addr0, pat}),
    .cfg_addr_o(addr0), .adc_rst_b_o(rstb0), .adc_cs_b_o(cs0), .adc_sclk_o(sclk0),
    .adc_sdata_o(sd0), .adc_rdy_o(rdy0), .init_state_o(st0)
`ifdef ADC_FRAME_CNT_EN
    , .frames_sent_o(fr0)
`endif
  );
  adc_init_seq #(.NREG(1), .RST_PW(1), .PWR_WAIT(1), .SCLK_DIV(1)) u1 (
    .clk_i(clk), .rst_i(rst), .adc_init_rst_i(init_rst), .cfg_data_i({addr1, pat}),
    .cfg_addr_o(addr1), .adc_rst_b_o(rstb1), .adc_cs_b_o(cs1), .adc_sclk_o(sclk1),
    .adc_sdata_o(sd1), .adc_rdy_o(rdy1), .init_state_o(st1)
`ifdef ADC_FRAME_CNT_EN
    , .frames_sent_o(fr1)
`endif
  );
  assign o_rstb = sel ? rstb1 : rstb0;
  assign o_cs   = sel ? cs1 : cs0;
  assign o_sclk = sel ? sclk1 : sclk0;
  assign o_sd   = sel ? sd1 : sd0;
  assign o_rdy  = sel ? rdy1 : rdy0;
  assign o_st   = sel ? st1 : st0;
  assign o_addr = sel ? addr1 : addr0;

  task automatic start();
    init_rst = 1'b1;
    repeat (3) @(negedge clk);
    init_rst = 1'b0;
  endtask

  // records sample k (taken after posedge k) as seen on the selected instance
  task automatic observe(input int n);
    logic pcs, psclk, psd, in_gap;
    logic [23:0] w;
    int run, gap, nb, last_chg, d;
    d = sel ? 1 : DIV;
    runs.delete(); gaps.delete(); bits.delete(); words.delete();
    rstb_rise = -1; rdy_rise = -1; first_cs = -1; viol = 0;
    pcs = 1'b1; psclk = 1'b0; psd = 1'b0; in_gap = 1'b0;
    run = 0; gap = 0; nb = 0; w = '0; last_chg = -1000;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rstb_rise < 0 && o_rstb) rstb_rise = k;
      if (rdy_rise < 0 && o_rdy) rdy_rise = k;
      if (o_sd != psd) last_chg = k;
      if (o_cs && o_sclk) viol++;
      if (!o_cs) begin
        if (first_cs < 0) first_cs = k;
        if (pcs && in_gap) gaps.push_back(gap);
        run++;
        if (o_sclk && !psclk) begin
          w = {w[22:0], o_sd};
          nb++;
          if (k - last_chg < d) viol++;
        end
        if (o_sd != psd && !pcs && o_sclk) viol++;
      end else if (!pcs) begin
        runs.push_back(run); words.push_back(w); bits.push_back(nb);
        run = 0; nb = 0; w = '0; gap = 1; in_gap = 1'b1;
      end else gap++;
      pcs = o_cs; psclk = o_sclk; psd = o_sd;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rstb0, cs0, sclk0, sd0, rdy0, addr0, st0} !== {5'b01000, 4'd0, 3'd0}) begin
      errors++; $display("FAIL reset_u0: got %b want %b", {rstb0, cs0, sclk0, sd0, rdy0, addr0, st0}, 12'b010000000000);
    end
    checks++;
    if ({rstb1, cs1, sclk1, sd1, rdy1, addr1, st1} !== {5'b01000, 4'd0, 3'd0}) begin
      errors++; $display("FAIL reset_u1: got %b want %b", {rstb1, cs1, sclk1, sd1, rdy1, addr1, st1}, 12'b010000000000);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal(input logic s, input logic [19:0] p);
    int rp, pw, nr, d, t;
    sel = s; pat = p;
    rp = s ? 1 : RST_PW; pw = s ? 1 : PWR_WAIT; nr = s ? 1 : NREG; d = s ? 1 : DIV;
    t = rp + pw + nr * 49 * d;
    start();
    observe(t + 10);
    checks++;
    if (rstb_rise !== rp) begin errors++; $display("FAIL rst_b_rise(sel=%0d): got %0d want %0d", s, rstb_rise, rp); end
    checks++;
    if (first_cs !== rp + pw) begin errors++; $display("FAIL first_cs(sel=%0d): got %0d want %0d", s, first_cs, rp + pw); end
    checks++;
    if (rdy_rise !== t) begin errors++; $display("FAIL rdy_rise(sel=%0d): got %0d want %0d", s, rdy_rise, t); end
    checks++;
    if (runs.size() !== nr) begin errors++; $display("FAIL frame_count(sel=%0d): got %0d want %0d", s, runs.size(), nr); end
    for (int i = 0; i < runs.size() && i < nr; i++) begin
      checks++;
      if (runs[i] !== 48 * d) begin errors++; $display("FAIL cs_low_len[%0d]: got %0d want %0d", i, runs[i], 48 * d); end
      checks++;
      if (bits[i] !== 24) begin errors++; $display("FAIL sclk_rises[%0d]: got %0d want 24", i, bits[i]); end
      checks++;
      if (words[i] !== {4'(i), p}) begin errors++; $display("FAIL frame_word[%0d]: got %h want %h", i, words[i], {4'(i), p}); end
    end
    for (int i = 0; i < gaps.size(); i++) begin
      checks++;
      if (gaps[i] !== d) begin errors++; $display("FAIL cs_gap[%0d]: got %0d want %0d", i, gaps[i], d); end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL spi_timing(sel=%0d): got %0d violations want 0", s, viol); end
    checks++;
    if (o_st !== 3'd5) begin errors++; $display("FAIL done_state(sel=%0d): got %0d want 5", s, o_st); end
  endtask

  task automatic test_abort();
    int f, b, r, ka;
    sel = 1'b0; pat = 20'($urandom);
    f = $urandom_range(0, NREG - 1); b = $urandom_range(0, 22); r = $urandom_range(0, 2 * DIV - 1);
    ka = RST_PW + PWR_WAIT + f * 49 * DIV + 2 * b * DIV + r;
    start();
    observe(ka + 1);
    checks++;
    if (words.size() !== f) begin errors++; $display("FAIL frames_before_abort: got %0d want %0d", words.size(), f); end
    checks++;
    if (o_cs !== 1'b0) begin errors++; $display("FAIL mid_frame_cs: got %b want 0", o_cs); end
    init_rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_cs, o_sclk, o_rstb, o_rdy, o_st, o_addr} !== {4'b1000, 3'd0, 4'd0}) begin
      errors++; $display("FAIL abort_outputs: got %b want %b", {o_cs, o_sclk, o_rstb, o_rdy, o_st, o_addr}, 11'b10000000000);
    end
    test_nominal(1'b0, pat);
  endtask

  task automatic test_async_rst();
    sel = 1'b0;
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL pre_rst_rdy: got %b want 1", rdy0); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rdy0, rstb0, cs0, st0} !== {3'b001, 3'd0}) begin
      errors++; $display("FAIL async_rst: got %b want %b", {rdy0, rstb0, cs0, st0}, 6'b001000);
    end
    init_rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_high();
    sel = 1'b0; init_rst = 1'b1;
    observe(5000);
    checks++;
    if (first_cs !== -1) begin errors++; $display("FAIL hold_cs_activity: got %0d want -1", first_cs); end
    checks++;
    if (rdy_rise !== -1 || rstb_rise !== -1) begin errors++; $display("FAIL hold_rdy_rstb: got %0d/%0d want -1/-1", rdy_rise, rstb_rise); end
    checks++;
    if (o_st !== 3'd0) begin errors++; $display("FAIL hold_state: got %0d want 0", o_st); end
  endtask

`ifdef ADC_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int f, ka;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checks++;
    if (fr0 !== 8'd0) begin errors++; $display("FAIL frames_after_rst: got %0d want 0", fr0); end
    repeat (3) begin
      start();
      repeat (T0 + 5) @(negedge clk);
    end
    f = $urandom_range(0, NREG - 1);
    ka = RST_PW + PWR_WAIT + f * 49 * DIV + 2 * $urandom_range(0, 22) * DIV + 1;
    start();
    repeat (ka + 1) @(negedge clk);
    init_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (fr0 !== 8'(3 * NREG + f)) begin errors++; $display("FAIL frames_sent: got %0d want %0d", fr0, 3 * NREG + f); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal(1'b0, 20'hA5A50);
    test_async_rst();
    test_nominal(1'b0, 20'($urandom));
    test_abort();
    test_nominal(1'b1, 20'($urandom));
    test_hold_high();
`ifdef ADC_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
